// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and default widths for the memory arbiter
package arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_D,
    S_WAIT_D,
    S_RESP_D,
    S_ISSUE_I,
    S_WAIT_I,
    S_RESP_I
  } arb_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_DM
  } arb_port_t;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 3;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch and load/store ports
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_valid,
  output logic              stall_if,
  output logic              stall_dm
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic          grant_any;
  arb_port_t     grant_port;

  // Data wins ties unless fetch has already waited through STARVE_MAX data grants.
  always_comb begin
    grant_any  = (state == S_IDLE) && (if_req || dm_req);
    grant_port = PORT_DM;
    if (if_req && (!dm_req || starve_cnt == STARVE_TOP))
      grant_port = PORT_IF;
  end

  assign stall_if = if_req & ~if_ready;
  assign stall_dm = dm_req & ~dm_ready;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
    end else begin
      m_req    <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_any) begin
            m_req <= 1'b1;
            if (grant_port == PORT_IF) begin
              state  <= S_ISSUE_I;
              m_addr <= if_addr;
              m_we   <= 1'b0;
            end else begin
              state   <= S_ISSUE_D;
              m_addr  <= dm_addr;
              m_we    <= dm_we;
              m_wdata <= dm_wdata;
            end
          end
        end
        S_ISSUE_D: state <= S_WAIT_D;
        S_ISSUE_I: state <= S_WAIT_I;
        S_WAIT_D: begin
          if (m_valid) begin
            state    <= S_RESP_D;
            dm_ready <= 1'b1;
            if (!m_we) dm_rdata <= m_rdata;
          end
        end
        S_WAIT_I: begin
          if (m_valid) begin
            state    <= S_RESP_I;
            if_ready <= 1'b1;
            if_rdata <= m_rdata;
          end
        end
        S_RESP_D: state <= S_IDLE;
        S_RESP_I: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase

      // Counts data grants that overtook a waiting fetch.
      if (!if_req || (grant_any && grant_port == PORT_IF))
        starve_cnt <= '0;
      else if (grant_any && grant_port == PORT_DM && starve_cnt != STARVE_TOP)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_valid = 1'b0;
  logic        stall_if;
  logic        stall_dm;

  int total = 0;
  int bad = 0;

  int          mem_lat = 1;
  logic [31:0] mem_rd = '0;
  bit          spur = 1'b0;
  int          mem_cnt = 0;

  logic        pend_d = 1'b0, pend_i = 1'b0, pwe_d = 1'b0;
  logic [31:0] pa_d = '0, pa_i = '0;

  mem_arbiter dut (
    .CLK(CLK), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_valid(m_valid),
    .stall_if(stall_if), .stall_dm(stall_dm)
  );

  always #5 CLK = ~CLK;

  // Memory: answers mem_lat cycles after each m_req; the counter survives reset on purpose.
  always @(negedge CLK) begin
    m_valid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        m_valid = 1'b1;
        m_rdata = mem_rd;
      end
    end
    if (spur) begin
      m_valid = 1'b1;
      m_rdata = mem_rd;
      spur = 1'b0;
    end
    if (m_req) mem_cnt = mem_lat;
  end

  // Requesters must hold req/addr/we from assertion through the ready cycle.
  always @(negedge CLK) begin
    if (!reset) begin
      pend_d = 1'b0;
      pend_i = 1'b0;
    end else begin
      if (pend_d) begin
        total++;
        assert (dm_req === 1'b1 && dm_addr === pa_d && dm_we === pwe_d)
        else begin
          bad++;
          $error("FAIL dm_req_stable observed req=%b addr=%h expected req=1 addr=%h", dm_req, dm_addr, pa_d);
        end
      end
      if (pend_i) begin
        total++;
        assert (if_req === 1'b1 && if_addr === pa_i)
        else begin
          bad++;
          $error("FAIL if_req_stable observed req=%b addr=%h expected req=1 addr=%h", if_req, if_addr, pa_i);
        end
      end
      pend_d = dm_req & ~dm_ready;
      pa_d   = dm_addr;
      pwe_d  = dm_we;
      pend_i = if_req & ~if_ready;
      pa_i   = if_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(input bit port_dm, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (port_dm ? dm_ready : if_ready) return;
    end
    n = -1;
  endtask

  task automatic wait_any_ready(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (dm_ready || if_ready) return;
    end
    n = -1;
  endtask

  task automatic wait_mreq(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (m_req) return;
    end
    n = -1;
  endtask

  initial begin
    int          n;
    logic [31:0] grants [4];
    bit          seen;

    // Reset state
    tick();
    tick();
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_dm_ready", dm_ready, 0);
    chk("rst_stall_if", stall_if, 0);
    reset = 1'b1;
    tick();

    // Lone fetch, L=1
    mem_lat = 1;
    mem_rd  = 32'h2008_0005;
    if_addr = 32'h0000_0040;
    if_req  = 1'b1;
    #1;
    chk("fetch_stall_t0", stall_if, 1);
    tick();
    chk("fetch_m_req_t1", m_req, 1);
    chk("fetch_m_addr_t1", m_addr, 32'h40);
    chk("fetch_m_we_t1", m_we, 0);
    chk("fetch_stall_t1", stall_if, 1);
    tick();
    chk("fetch_m_req_t2", m_req, 0);
    chk("fetch_stall_t2", stall_if, 1);
    tick();
    chk("fetch_ready_t3", if_ready, 1);
    chk("fetch_rdata_t3", if_rdata, 32'h2008_0005);
    chk("fetch_stall_t3", stall_if, 0);
    chk("fetch_dm_ready_t3", dm_ready, 0);
    tick();
    if_req = 1'b0;
    chk("fetch_ready_t4", if_ready, 0);
    tick();

    // Simultaneous store and fetch: store first
    mem_rd   = 32'h1357_9BDF;
    dm_we    = 1'b1;
    dm_addr  = 32'h80;
    dm_wdata = 32'hDEAD_BEEF;
    dm_req   = 1'b1;
    if_addr  = 32'h44;
    if_req   = 1'b1;
    tick();
    chk("both_m_req_t1", m_req, 1);
    chk("both_m_we_t1", m_we, 1);
    chk("both_m_addr_t1", m_addr, 32'h80);
    chk("both_m_wdata_t1", m_wdata, 32'hDEAD_BEEF);
    tick();
    tick();
    chk("both_dm_ready_t3", dm_ready, 1);
    chk("both_if_ready_t3", if_ready, 0);
    chk("both_store_dm_rdata", dm_rdata, 0);
    tick();
    dm_req = 1'b0;
    dm_we  = 1'b0;
    chk("both_m_req_t4", m_req, 0);
    chk("both_stall_if_t4", stall_if, 1);
    tick();
    chk("both_fetch_m_req_t5", m_req, 1);
    chk("both_fetch_addr_t5", m_addr, 32'h44);
    chk("both_fetch_we_t5", m_we, 0);
    wait_ready(1'b0, 20, n);
    chk("both_fetch_ready_lat", n, 2);
    chk("both_fetch_rdata", if_rdata, 32'h1357_9BDF);
    tick();
    if_req = 1'b0;
    tick();

    // Starvation guard: three data grants, then fetch
    mem_rd  = 32'h1111_2222;
    if_addr = 32'h48;
    if_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h200;
    dm_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_mreq(20, n);
      grants[k] = m_addr;
      if (k == 2) chk("starve_cnt_full", dut.starve_cnt, 3);
      if (k == 3) chk("starve_cnt_clear", dut.starve_cnt, 0);
      wait_any_ready(20, n);
      if (k == 3) begin
        tick();
        if_req = 1'b0;
      end
    end
    chk("starve_grant0", grants[0], 32'h200);
    chk("starve_grant1", grants[1], 32'h200);
    chk("starve_grant2", grants[2], 32'h200);
    chk("starve_grant3", grants[3], 32'h48);
    wait_ready(1'b1, 20, n);
    chk("starve_tail_ready", n, 3);
    tick();
    dm_req = 1'b0;
    chk("starve_cnt_idle", dut.starve_cnt, 0);
    tick();

    // Slow memory load, L=5
    mem_lat = 5;
    mem_rd  = 32'hCAFE_0100;
    dm_addr = 32'h100;
    dm_req  = 1'b1;
    wait_ready(1'b1, 30, n);
    chk("slow_ready_lat", n, 7);
    chk("slow_dm_rdata", dm_rdata, 32'hCAFE_0100);
    chk("slow_if_rdata_kept", if_rdata, 32'h1111_2222);
    tick();
    dm_req = 1'b0;
    tick();

    // Reset while waiting on a load
    mem_rd  = 32'h3333_0000;
    dm_addr = 32'h300;
    dm_req  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_m_req", m_req, 0);
    chk("mid_rst_m_addr", m_addr, 0);
    chk("mid_rst_dm_rdata", dm_rdata, 0);
    chk("mid_rst_if_rdata", if_rdata, 0);
    dm_req = 1'b0;
    #1;
    chk("mid_rst_stall_dm", stall_dm, 0);
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (if_ready || dm_ready || m_req) seen = 1'b1;
    end
    chk("stray_valid_no_activity", seen, 0);
    mem_lat = 1;
    mem_rd  = 32'h4444_5555;
    dm_addr = 32'h304;
    dm_req  = 1'b1;
    wait_ready(1'b1, 20, n);
    chk("post_rst_ready_lat", n, 3);
    chk("post_rst_dm_rdata", dm_rdata, 32'h4444_5555);
    tick();
    dm_req = 1'b0;
    tick();

    // Spurious m_valid in IDLE and in RESP_I
    mem_rd = 32'h7777_7777;
    spur   = 1'b1;
    tick();
    chk("spur_idle_m_req", m_req, 0);
    chk("spur_idle_ready", {if_ready, dm_ready}, 0);
    tick();
    chk("spur_idle_ready2", {if_ready, dm_ready}, 0);
    mem_rd  = 32'h5555_6666;
    if_addr = 32'h4C;
    if_req  = 1'b1;
    wait_ready(1'b0, 20, n);
    chk("spur_fetch_lat", n, 3);
    chk("spur_fetch_rdata", if_rdata, 32'h5555_6666);
    mem_rd = 32'hBAD0_BAD0;
    spur   = 1'b1;
    tick();
    if_req = 1'b0;
    chk("spur_resp_ready", {if_ready, dm_ready}, 0);
    chk("spur_resp_m_req", m_req, 0);
    tick();
    chk("spur_resp_ready2", {if_ready, dm_ready}, 0);
    chk("spur_resp_m_req2", m_req, 0);
    chk("spur_resp_if_rdata", if_rdata, 32'h5555_6666);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the five-stage pipeline. It shares one unified instruction/data memory between the fetch port (IF) and the load/store port (MEM). One transaction is in flight at a time. Requests are served with fixed data-over-fetch priority plus a starvation guard. The block emits per-port stall signals, which the hazard logic folds into StallF, StallD and FlushE.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 3: consecutive data grants allowed while IF waits, ≥1.

Ports:
- `CLK`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `if_req`  in  1: fetch request.
- `if_addr`  in  ADDR_W: fetch address (PCF).
- `if_rdata`  out  DATA_W: fetched instruction.
- `if_ready`  out  1: one-cycle completion pulse for IF.
- `dm_req`  in  1: load/store request.
- `dm_we`  in  1: 1 = store.
- `dm_addr`  in  ADDR_W: data address (ALUOutM).
- `dm_wdata`  in  DATA_W: store data (WriteDataM).
- `dm_rdata`  out  DATA_W: load data.
- `dm_ready`  out  1: one-cycle completion pulse for MEM.
- `m_req`  out  1: memory command strobe, one cycle.
- `m_we`  out  1: memory write enable.
- `m_addr`  out  ADDR_W: memory address.
- `m_wdata`  out  DATA_W: memory write data.
- `m_rdata`  in  DATA_W: memory read data.
- `m_valid`  in  1: memory done (read data valid, or write ack).
- `stall_if`  out  1: `if_req & ~if_ready`.
- `stall_dm`  out  1: `dm_req & ~dm_ready`.

## Operation
- States:
  - IDLE.
  - ISSUE_D / ISSUE_I: `m_req` high, one cycle.
  - WAIT_D / WAIT_I: await `m_valid`.
  - RESP_D / RESP_I: ready pulse.
- Arbitration happens only in IDLE:
  - Only `dm_req` → ISSUE_D.
  - Only `if_req` → ISSUE_I.
  - Both: ISSUE_I if `starve_cnt == STARVE_MAX`, else ISSUE_D.
  - Neither → stay in IDLE.
- On the grant edge, latch the granted port's addr, we and wdata into command registers. `m_addr`, `m_we` and `m_wdata` are driven only from these registers. IF grants force `m_we = 0`.
- ISSUE_x → WAIT_x unconditionally.
- WAIT_x → RESP_x on the first cycle with `m_valid = 1`. Latch `m_rdata` into the port's rdata register on that edge.
- RESP_x: `x_ready = 1`. Next state is always IDLE.
- `if_rdata` and `dm_rdata` hold their last latched value until the next completion on that port. For stores, `dm_rdata` is unchanged.
- Starvation counter `starve_cnt` is `$clog2(STARVE_MAX+1)` bits wide:
  - Increments on a data grant while `if_req = 1`.
  - Clears on any IF grant, and in any cycle with `if_req = 0`.
  - Saturates at STARVE_MAX.
- Requester rule: req, addr, we and wdata stay stable from assertion through the ready cycle. Req is deasserted or retargeted only after ready. Violations are undefined; the bench asserts on them.
- `m_valid` outside WAIT_x is ignored. This covers late responses after reset.

## Timing
- Reset (`reset = 0`, async) puts the FSM in IDLE and clears `starve_cnt`.
- Reset values: `m_req`, `m_we`, `if_ready`, `dm_ready` = 0; `m_addr`, `m_wdata`, `if_rdata`, `dm_rdata` = 0.
- Stalls are combinational and therefore 0 whenever the requests are 0.
- Reset mid-transaction abandons the transaction: no ready pulse, and any returning `m_valid` is ignored.
- Latency with req sampled in IDLE at cycle t and memory response delay L ≥ 1 cycles after `m_req`:
  - `m_req` in cycle t+1.
  - `m_valid` in cycle t+1+L.
  - `x_ready` in cycle t+2+L.
  - Next arbitration in cycle t+3+L.
- Minimum request-to-ready is 3 cycles (L=1).
- Back-to-back: the loser of a simultaneous request is issued at t+4+L.
- `m_req` is high for exactly one cycle per transaction; at most one transaction is outstanding.
- Ready is high exactly one cycle per transaction, and never on both ports in the same cycle.

## Structure
- `arb_pkg` holds:
  - The state enum `arb_state_t` (7 states).
  - The grant enum `arb_port_t {PORT_IF, PORT_DM}`.
  - The default width constants.
- No sub-module is needed. The FSM, command registers and starvation counter sit in one module of about 200 lines.

## Test plan
- Lone fetch: `if_req = 1`, `if_addr = 0x0000_0040`, memory L=1 returns 0x2008_0005 → `m_req` at t+1 with `m_addr = 0x40`, `m_we = 0`; `if_ready` at t+3 with `if_rdata = 0x2008_0005`; `stall_if = 1` in t..t+2.
- Simultaneous requests: both high, `dm_we = 1`, `dm_addr = 0x80`, `dm_wdata = 0xDEAD_BEEF` → store issued first (`m_we = 1`), `dm_ready` at t+3; fetch `m_req` at t+5.
- Starvation: `if_req` held while `dm_req` is re-raised after every ready → exactly 3 data grants, then the IF grant; `starve_cnt` returns to 0.
- Slow memory L=5 load from 0x100 → `dm_ready` at t+7, `dm_rdata` latched, `if_rdata` unchanged.
- Reset in WAIT_D → all outputs 0 immediately; the later stray `m_valid` produces no ready; the next request is served normally.
- Spurious `m_valid` pulses in IDLE and RESP_I → no state change, no extra ready pulse.
